// File: rtl/rshp_rd_ctrl.sv
// rshp_rd_ctrl -- read-side sequencer for the reshaper byte FIFO.
//
// A job of cfg_len bytes is pulled out of the byte FIFO in chunks of
// cfg_obyte bytes. A read is issued only when enough bytes are resident and
// the output buffer has room for the returning beat. Each returned chunk has
// its unused tail bytes zeroed and is presented as one output beat with byte
// enables and a last flag.
//
// Optional feature macro: RSHP_RDC_STALLCNT_EN
//   When defined, adds the stall_cnt output. It counts RUN cycles that were
//   blocked only by too few resident bytes. It saturates, clears on an
//   accepted start, and holds after the job ends.
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   start             job start pulse, accepted only while idle
//   cfg_len           total job bytes, sampled on accepted start
//   cfg_obyte         bytes per beat (0 means DW/8), sampled on accepted start
//   busy, done        job in progress / one-cycle completion pulse
//   ffrreq, ffrbyte   FIFO read request and number of bytes consumed
//   ffrdata, ffrvld   FIFO read data, valid one cycle after ffrreq
//   ffvbyte           bytes currently resident in the FIFO
//   odata, obe, olast output beat, byte enables, final-beat flag
//   ovalid, oready    output handshake
//   stall_cnt         (RSHP_RDC_STALLCNT_EN only) stall cycle counter
module rshp_rd_ctrl #(
  parameter int DW    = 512,
  parameter int BUFFW = DW * 2,
  parameter int LW    = 24
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [LW-1:0]             cfg_len,
  input  logic [$clog2(DW/8):0]     cfg_obyte,
  output logic                      busy,
  output logic                      done,
  output logic                      ffrreq,
  output logic [$clog2(DW/8):0]     ffrbyte,
  input  logic [DW-1:0]             ffrdata,
  input  logic                      ffrvld,
  input  logic [$clog2(BUFFW/8):0]  ffvbyte,
  output logic [DW-1:0]             odata,
  output logic [DW/8-1:0]           obe,
  output logic                      olast,
  output logic                      ovalid,
  input  logic                      oready
`ifdef RSHP_RDC_STALLCNT_EN
  ,
  output logic [31:0]               stall_cnt
`endif
);

  localparam int NB  = DW / 8;
  localparam int OBW = $clog2(NB) + 1;
  localparam int VBW = $clog2(BUFFW / 8) + 1;
  localparam int CW  = (VBW > OBW) ? VBW : OBW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [LW-1:0]   remaining;
  logic [OBW-1:0]  obyte_q;
  logic [OBW-1:0]  obyte_norm;
  logic [OBW-1:0]  rbyte;

  // In-flight tag for the single outstanding FIFO read.
  logic            tag_vld;
  logic [OBW-1:0]  tag_size;
  logic            tag_last;

  // Two-entry skid buffer.
  logic [DW-1:0]   sk_data [2];
  logic [NB-1:0]   sk_be   [2];
  logic [1:0]      sk_last;
  logic            wr_ptr;
  logic            rd_ptr;
  logic [1:0]      occ;

  logic            start_acc;
  logic            enough;
  logic            room;
  logic            issue;
  logic            stall;
  logic            push;
  logic            pop;

  logic [DW-1:0]   ret_data;
  logic [NB-1:0]   ret_be;

  // ---------------------------------------------------------------------
  // Configuration normalisation and chunk sizing
  // ---------------------------------------------------------------------
  always_comb begin
    obyte_norm = cfg_obyte;
    if (cfg_obyte == '0 || cfg_obyte > OBW'(NB)) begin
      obyte_norm = OBW'(NB);
    end
  end

  always_comb begin
    rbyte = obyte_q;
    if (remaining < LW'(obyte_q)) begin
      rbyte = remaining[OBW-1:0];
    end
  end

  // ---------------------------------------------------------------------
  // Output handshake on the skid head
  // ---------------------------------------------------------------------
  assign ovalid = (occ != 2'd0);
  assign pop    = ovalid && oready;
  assign push   = ffrvld && tag_vld;
  assign odata  = sk_data[rd_ptr];
  assign obe    = sk_be[rd_ptr];
  assign olast  = sk_last[rd_ptr];

  // Credit is 2 - occupancy - inflight; a pop in the same cycle frees a slot
  // early so back-to-back reads are sustained while oready stays high.
  assign room = ({1'b0, occ} + {2'b00, tag_vld}) < (3'd2 + {2'b00, pop});

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (cfg_len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (remaining == '0) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && olast) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs / read issue
  // ---------------------------------------------------------------------
  always_comb begin
    start_acc = (state == S_IDLE) && start;
    enough    = CW'(ffvbyte) >= CW'(rbyte);
    issue     = (state == S_RUN) && (remaining != '0) && enough && room;
    stall     = (state == S_RUN) && (remaining != '0) && !enough;
    ffrreq    = issue;
    ffrbyte   = issue ? rbyte : '0;
  end

  // ---------------------------------------------------------------------
  // Job bookkeeping; busy and done are registered so they reflect the
  // DONE state one cycle after it is entered.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      remaining <= '0;
      obyte_q   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= (state == S_DONE);
      if (start_acc) begin
        remaining <= cfg_len;
        obyte_q   <= obyte_norm;
        busy      <= 1'b1;
      end else begin
        if (issue) begin
          remaining <= remaining - LW'(rbyte);
        end
        if (state == S_DONE) begin
          busy <= 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // In-flight tag: captured on issue, released when the data returns.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_vld  <= 1'b0;
      tag_size <= '0;
      tag_last <= 1'b0;
    end else if (issue) begin
      tag_vld  <= 1'b1;
      tag_size <= rbyte;
      tag_last <= (remaining == LW'(rbyte));
    end else if (ffrvld) begin
      tag_vld  <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Return path: zero the tail bytes and build byte enables from the tag.
  // ---------------------------------------------------------------------
  always_comb begin
    ret_data = '0;
    ret_be   = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      if (i < 32'(tag_size)) begin
        ret_be[i]         = 1'b1;
        ret_data[i*8 +: 8] = ffrdata[i*8 +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Skid buffer
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < 2; i++) begin
        sk_data[i] <= '0;
        sk_be[i]   <= '0;
      end
      sk_last <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      occ     <= '0;
    end else begin
      if (push) begin
        sk_data[wr_ptr] <= ret_data;
        sk_be[wr_ptr]   <= ret_be;
        sk_last[wr_ptr] <= tag_last;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

`ifdef RSHP_RDC_STALLCNT_EN
  // ---------------------------------------------------------------------
  // Stall counter
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
    end else if (start_acc) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rshp_rd_ctrl.sv
// Self-checking bench for rshp_rd_ctrl: directed jobs, a FIFO responder model
// and a scoreboard monitor that checks every output beat.
module tb_rshp_rd_ctrl;

  localparam int DW  = 512;
  localparam int NB  = DW / 8;
  localparam int LW  = 24;
  localparam int OBW = 7;
  localparam int VBW = 8;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            start;
  logic [LW-1:0]   cfg_len;
  logic [OBW-1:0]  cfg_obyte;
  logic            busy;
  logic            done;
  logic            ffrreq;
  logic [OBW-1:0]  ffrbyte;
  logic [DW-1:0]   ffrdata;
  logic            ffrvld;
  logic [VBW-1:0]  ffvbyte;
  logic [DW-1:0]   odata;
  logic [NB-1:0]   obe;
  logic            olast;
  logic            ovalid;
  logic            oready;
`ifdef RSHP_RDC_STALLCNT_EN
  logic [31:0]     stall_cnt;
`endif

  always #5 clk = ~clk;

  rshp_rd_ctrl #(.DW(DW), .BUFFW(DW * 2), .LW(LW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .cfg_len   (cfg_len),
    .cfg_obyte (cfg_obyte),
    .busy      (busy),
    .done      (done),
    .ffrreq    (ffrreq),
    .ffrbyte   (ffrbyte),
    .ffrdata   (ffrdata),
    .ffrvld    (ffrvld),
    .ffvbyte   (ffvbyte),
    .odata     (odata),
    .obe       (obe),
    .olast     (olast),
    .ovalid    (ovalid),
    .oready    (oready)
`ifdef RSHP_RDC_STALLCNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int size;
    bit last;
  } exp_t;
  exp_t exp_q[$];

  // FIFO model: resident bytes = loaded - consumed, clamped to the port range.
  int avail_base = 0;
  int consumed   = 0;
  int rd_cnt     = 0;

  function automatic logic [VBW-1:0] clampv(input int v);
    if (v < 0)   return '0;
    if (v > 255) return '1;
    return VBW'(v);
  endfunction

  assign ffvbyte = clampv(avail_base - consumed);

  function automatic logic [7:0] fbyte(input int n, input int j);
    return 8'(n * 37 + j * 5 + 1);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // FIFO responder: data returns one cycle after each read request.
  initial begin
    ffrvld  = 1'b0;
    ffrdata = '0;
    forever begin
      logic req;
      int   b;
      @(negedge clk);
      req = ffrreq;
      b   = int'(ffrbyte);
      @(posedge clk);
      #1;
      if (!reset_n) begin
        ffrvld   = 1'b0;
        rd_cnt   = 0;
        consumed = 0;
      end else if (req) begin
        ffrvld = 1'b1;
        for (int j = 0; j < NB; j++) ffrdata[j*8 +: 8] = fbyte(rd_cnt, j);
        rd_cnt++;
        consumed += b;
      end else begin
        ffrvld = 1'b0;
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    int            beat_cnt;
    bit            held;
    bit            prev_req;
    logic [DW-1:0] hd;
    logic [NB-1:0] hb;
    logic          hl;
    logic [DW-1:0] expd;
    logic [NB-1:0] expb;
    exp_t          e;
    beat_cnt = 0;
    held     = 1'b0;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        beat_cnt = 0;
        held     = 1'b0;
        prev_req = 1'b0;
      end else begin
        assert (!ffrvld || prev_req) else $error("protocol: ffrvld without a preceding read request");
        prev_req = ffrreq;
        if (ovalid) begin
          if (held) begin
            chk("hold_stable", 64'(odata === hd && obe === hb && olast === hl), 64'd1);
          end
          if (oready) begin
            held = 1'b0;
            if (exp_q.size() == 0) begin
              chk("unexpected_beat", 64'd1, 64'd0);
            end else begin
              e = exp_q.pop_front();
              expd = '0;
              expb = '0;
              for (int j = 0; j < NB; j++) begin
                if (j < e.size) begin
                  expb[j]         = 1'b1;
                  expd[j*8 +: 8]  = fbyte(beat_cnt, j);
                end
              end
              n_chk++;
              if (odata !== expd) begin
                n_fail++;
                $display("FAIL beat%0d_data: got %h expected %h", beat_cnt, odata, expd);
              end
              chk($sformatf("beat%0d_be", beat_cnt), 64'(obe), 64'(expb));
              chk($sformatf("beat%0d_last", beat_cnt), 64'(olast), 64'(e.last));
            end
            beat_cnt++;
          end else begin
            held = 1'b1;
            hd   = odata;
            hb   = obe;
            hl   = olast;
          end
        end else begin
          held = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int size, input bit last);
    exp_t e;
    e.size = size;
    e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic start_job(input int len, input int ob);
    cfg_len   = LW'(len);
    cfg_obyte = OBW'(ob);
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic check_read(input string nm, input int b);
    @(negedge clk);
    chk({nm, "_req"}, 64'(ffrreq), 64'(b != 0));
    chk({nm, "_byte"}, 64'(ffrbyte), 64'(b));
  endtask

  task automatic check_db(input string nm, input bit d, input bit b);
    @(negedge clk);
    chk({nm, "_done"}, 64'(done), 64'(d));
    chk({nm, "_busy"}, 64'(busy), 64'(b));
  endtask

  task automatic wait_done(input string nm, input int maxc);
    int k;
    bit seen;
    k    = 0;
    seen = 1'b0;
    while (k < maxc && !seen) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      k++;
    end
    chk({nm, "_done_seen"}, 64'(seen), 64'd1);
    chk({nm, "_busy_at_done"}, 64'(busy), 64'd0);
    @(negedge clk);
    chk({nm, "_done_pulse"}, 64'(done), 64'd0);
    chk({nm, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    cfg_len   = '0;
    cfg_obyte = '0;
    oready    = 1'b1;
    tick();
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ffrreq", 64'(ffrreq), 64'd0);
    chk("rst_ovalid", 64'(ovalid), 64'd0);
    chk("rst_odata_zero", 64'(odata == '0), 64'd1);
    reset_n = 1'b1;
    tick();

    // Job 1: 200 bytes in 64-byte chunks, free-flowing output.
    avail_base = consumed + 200;
    push_exp(64, 0); push_exp(64, 0); push_exp(64, 0); push_exp(8, 1);
    start_job(200, 64);
    check_read("j1_r0", 64);
    check_read("j1_r1", 64);
    check_read("j1_r2", 64);
    check_read("j1_r3", 8);
    check_read("j1_r4", 0);
    check_db("j1_c6", 1'b0, 1'b1);
    check_db("j1_c7", 1'b0, 1'b1);
    check_db("j1_c8", 1'b1, 1'b0);
    check_db("j1_c9", 1'b0, 1'b0);
    chk("j1_queue_empty", 64'(exp_q.size()), 64'd0);

    // Job 2: zero-length job.
    avail_base = consumed;
    start_job(0, 64);
    @(negedge clk);
    chk("j2_c1_done", 64'(done), 64'd0);
    chk("j2_c1_busy", 64'(busy), 64'd1);
    chk("j2_c1_ffrreq", 64'(ffrreq), 64'd0);
    chk("j2_c1_ovalid", 64'(ovalid), 64'd0);
    check_db("j2_c2", 1'b1, 1'b0);
    check_db("j2_c3", 1'b0, 1'b0);

    // Job 3: starved FIFO, then enough bytes arrive.
    avail_base = consumed + 10;
    push_exp(16, 0); push_exp(16, 0); push_exp(16, 1);
    start_job(48, 16);
    for (int i = 0; i < 5; i++) check_read($sformatf("j3_stall%0d", i), 0);
    tick();
    avail_base = consumed + 48;
    check_read("j3_r0", 16);
    check_read("j3_r1", 16);
    check_read("j3_r2", 16);
    check_read("j3_r3", 0);
    wait_done("j3", 20);
`ifdef RSHP_RDC_STALLCNT_EN
    chk("j3_stall_cnt", 64'(stall_cnt), 64'd5);
`endif

    // Job 4: downstream backpressure for 10 cycles.
    oready = 1'b0;
    avail_base = consumed + 256;
    push_exp(64, 0); push_exp(64, 0); push_exp(64, 0); push_exp(64, 1);
    start_job(256, 64);
    check_read("j4_r0", 64);
    check_read("j4_r1", 64);
    for (int i = 0; i < 8; i++) check_read($sformatf("j4_blocked%0d", i), 0);
    tick();
    oready = 1'b1;
    wait_done("j4", 30);

    // Job 5: a second start during RUN is ignored.
    avail_base = consumed + 128;
    push_exp(64, 0); push_exp(64, 1);
    start_job(128, 64);
    check_read("j5_r0", 64);
    tick();
    cfg_len   = LW'(64);
    cfg_obyte = OBW'(8);
    start     = 1'b1;
    check_read("j5_r1", 64);
    tick();
    start = 1'b0;
    check_read("j5_r2", 0);
    wait_done("j5", 20);

    // Job 6: reset asserted mid-job.
    oready = 1'b0;
    avail_base = consumed + 256;
    start_job(256, 64);
    tick();
    tick();
    tick();
    reset_n    = 1'b0;
    avail_base = 0;
    exp_q.delete();
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_ffrreq", 64'(ffrreq), 64'd0);
    chk("mid_rst_ffrbyte", 64'(ffrbyte), 64'd0);
    chk("mid_rst_ovalid", 64'(ovalid), 64'd0);
    chk("mid_rst_olast", 64'(olast), 64'd0);
    chk("mid_rst_obe", 64'(obe), 64'd0);
    chk("mid_rst_odata_zero", 64'(odata == '0), 64'd1);
    tick();
    tick();
    reset_n = 1'b1;
    oready  = 1'b1;
    tick();

    // Job 7: cfg_obyte=0 means 64-byte chunks; short final beat.
    avail_base = consumed + 130;
    push_exp(64, 0); push_exp(64, 0); push_exp(2, 1);
    start_job(130, 0);
    check_read("j7_r0", 64);
    check_read("j7_r1", 64);
    check_read("j7_r2", 2);
    check_read("j7_r3", 0);
    wait_done("j7", 20);
`ifdef RSHP_RDC_STALLCNT_EN
    chk("j7_stall_cnt", 64'(stall_cnt), 64'd0);
`endif

    repeat (4) tick();
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("final_ovalid", 64'(ovalid), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
